// File: rtl/reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_param                                                |
// | Function : Parametrised register file for the 8-bit MIPS datapath.      |
// |            Two registered read ports, one write port, optional           |
// |            hardwired-zero register 0, and a per-register pending         |
// |            scoreboard for decode-stage RAW hazard detection.             |
// |            Optional macro REGFILE_BYPASS_EN selects write-first reads    |
// |            when a read and a write hit the same address in one cycle.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             busy1,
  output logic             busy2,
  output logic             stall
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs_q      [DEPTH];
  logic [WIDTH-1:0] regs_d      [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [WIDTH-1:0] rd_data_q   [2];
  logic [WIDTH-1:0] rd_data_d   [2];
  logic [1:0]       busy_q;
  logic [1:0]       busy_d;
  logic [AW-1:0]    rd_addr_v   [2];

  // Next storage and scoreboard state: write clears pending, a claim then re-sets it
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en) begin
      if (!(ZERO_EN && (wr_addr == '0))) begin
        regs_d[wr_addr] = wr_data;
      end
      pending_d[wr_addr] = 1'b0;
    end
    if (claim_en) begin
      pending_d[claim_addr] = 1'b1;
    end
    // Register 0 can never be in flight when it is hardwired to zero
    if (ZERO_EN) begin
      pending_d[0] = 1'b0;
    end
  end

  // Read-port capture for both ports; outputs hold while rd_en is low
  always_comb begin
    rd_addr_v[0] = rd_addr1;
    rd_addr_v[1] = rd_addr2;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;
    if (rd_en) begin
      for (int p = 0; p < 2; p++) begin
`ifdef REGFILE_BYPASS_EN
        // Write-first: a same-cycle write is forwarded, and its pending
        // clear is seen unless a claim re-targets that register this cycle
        rd_data_d[p] = regs_d[rd_addr_v[p]];
        if (wr_en && (wr_addr == rd_addr_v[p])) begin
          busy_d[p] = pending_d[rd_addr_v[p]];
        end else begin
          busy_d[p] = pending_q[rd_addr_v[p]];
        end
`else
        // Read-first: decode sees the pre-write value and pre-clear pending bit
        rd_data_d[p] = regs_q[rd_addr_v[p]];
        busy_d[p]    = pending_q[rd_addr_v[p]];
`endif
        if (ZERO_EN && (rd_addr_v[p] == '0)) begin
          rd_data_d[p] = '0;
          busy_d[p]    = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset overriding all requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
      rd_data_q <= '{default: '0};
      busy_q    <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_data1 = rd_data_q[0];
  assign rd_data2 = rd_data_q[1];
  assign busy1    = busy_q[0];
  assign busy2    = busy_q[1];
  assign stall    = busy_q[0] | busy_q[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_file_param                                             |
// | Function : Self-checking bench for reg_file_param (DEPTH=4, WIDTH=8,     |
// |            ZERO_REG=1): directed vector tables plus random stimulus      |
// |            against a behavioural model.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       claim_en;
  logic [1:0] claim_addr;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic       busy1;
  logic       busy2;
  logic       stall;

  reg_file_param #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .busy1      (busy1),
    .busy2      (busy2),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       rd_en;
    logic [1:0] a1;
    logic [1:0] a2;
    logic       wr_en;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       claim_en;
    logic [1:0] ca;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       b1;
    logic       b2;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: architectural registers, in-flight flags, visible outputs
  logic [7:0] m_regs [4];
  bit         m_pend [4];
  logic [7:0] m_d1, m_d2;
  bit         m_b1, m_b2;

  function automatic vec_t mk(logic rn, logic re, logic [1:0] a1, logic [1:0] a2,
                              logic we, logic [1:0] wa, logic [7:0] wd,
                              logic ce, logic [1:0] ca,
                              logic [7:0] d1, logic [7:0] d2, logic b1, logic b2);
    vec_t v;
    v.rst_n = rn; v.rd_en = re; v.a1 = a1; v.a2 = a2;
    v.wr_en = we; v.wa = wa; v.wd = wd; v.claim_en = ce; v.ca = ca;
    v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One port's view of a read, from the architectural rules
  task automatic model_read(input logic [1:0] a, output logic [7:0] d, output bit b);
    if (a == 2'd0) begin
      d = 8'h00; b = 1'b0;
    end else if (BYP && wr_en && wr_addr == a) begin
      d = wr_data;
      b = claim_en && (claim_addr == a);
    end else begin
      d = m_regs[a]; b = m_pend[a];
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    if (!rst_n) begin
      foreach (m_regs[i]) begin m_regs[i] = 8'h00; m_pend[i] = 1'b0; end
      m_d1 = 8'h00; m_d2 = 8'h00; m_b1 = 1'b0; m_b2 = 1'b0;
    end else begin
      if (rd_en) begin
        model_read(rd_addr1, m_d1, m_b1);
        model_read(rd_addr2, m_d2, m_b2);
      end
      if (wr_en) begin
        if (wr_addr != 2'd0) m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (claim_en && claim_addr != 2'd0) m_pend[claim_addr] = 1'b1;
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; rd_en = v.rd_en; rd_addr1 = v.a1; rd_addr2 = v.a2;
    wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd;
    claim_en = v.claim_en; claim_addr = v.ca;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input vec_t v, input string tag);
    drive(v);
    check({tag, ".rd_data1"}, {24'd0, rd_data1}, {24'd0, v.d1});
    check({tag, ".rd_data2"}, {24'd0, rd_data2}, {24'd0, v.d2});
    check({tag, ".busy1"},    {31'd0, busy1},    {31'd0, v.b1});
    check({tag, ".busy2"},    {31'd0, busy2},    {31'd0, v.b2});
    check({tag, ".stall"},    {31'd0, stall},    {31'd0, v.b1 | v.b2});
  endtask

  vec_t tbl [20];
  vec_t hand [3];

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; claim_en = 1'b0; claim_addr = '0;
    foreach (m_regs[i]) begin m_regs[i] = 8'h00; m_pend[i] = 1'b0; end
    m_d1 = 8'h00; m_d2 = 8'h00; m_b1 = 1'b0; m_b2 = 1'b0;

    //           rn re a1 a2 we wa  wd     ce ca   d1     d2     b1 b2
    tbl[0]  = mk(0, 1, 1, 3, 1, 1, 8'hEE, 1, 2,  8'h00, 8'h00, 0, 0); // reset overrides all
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0);
    tbl[2]  = mk(1, 1, 1, 3, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0); // read after reset
    tbl[3]  = mk(1, 0, 0, 0, 1, 2, 8'hA5, 0, 0,  8'h00, 8'h00, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 3, 8'h3C, 0, 0,  8'h00, 8'h00, 0, 0);
    tbl[5]  = mk(1, 1, 2, 3, 0, 0, 8'h00, 0, 0,  8'hA5, 8'h3C, 0, 0); // basic read
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 8'hFF, 1, 0,  8'hA5, 8'h3C, 0, 0); // hold while rd_en=0
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0); // zero register
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1,  8'h00, 8'h00, 0, 0); // claim r1
    tbl[9]  = mk(1, 1, 1, 2, 0, 0, 8'h00, 0, 0,  8'h00, 8'hA5, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 8'h42, 1, 1,  8'h00, 8'hA5, 1, 0); // claim beats write
    tbl[11] = mk(1, 1, 1, 2, 0, 0, 8'h00, 0, 0,  8'h42, 8'hA5, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 8'h42, 0, 0,  8'h42, 8'hA5, 1, 0);
    tbl[13] = mk(1, 1, 1, 2, 0, 0, 8'h00, 0, 0,  8'h42, 8'hA5, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 1, 2, 8'h11, 0, 0,  8'h42, 8'hA5, 0, 0);
    tbl[15] = mk(1, 1, 2, 1, 1, 2, 8'h99, 0, 0,  BYP ? 8'h99 : 8'h11, 8'h42, 0, 0);
    tbl[16] = mk(1, 1, 2, 2, 0, 0, 8'h00, 0, 0,  8'h99, 8'h99, 0, 0); // same address twice
    tbl[17] = mk(1, 0, 0, 0, 1, 2, 8'h55, 1, 3,  8'h99, 8'h99, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0); // mid-stream reset
    tbl[19] = mk(1, 1, 2, 3, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 20; i++) apply_check(tbl[i], $sformatf("vec%0d", i));

    // Pending register written while read in the same cycle
    hand[0] = mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 3,  8'h00, 8'h00, 0, 0);
    hand[1] = mk(1, 1, 3, 0, 1, 3, 8'h77, 0, 0,  BYP ? 8'h77 : 8'h00, 8'h00, !BYP, 0);
    hand[2] = mk(1, 1, 3, 3, 0, 0, 8'h00, 0, 0,  8'h77, 8'h77, 0, 0);
    for (int i = 0; i < 3; i++) apply_check(hand[i], $sformatf("hand%0d", i));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = mk(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
             8'h00, 8'h00, 0, 0);
      drive(v);
      check("rnd.rd_data1", {24'd0, rd_data1}, {24'd0, m_d1});
      check("rnd.rd_data2", {24'd0, rd_data2}, {24'd0, m_d2});
      check("rnd.busy1",    {31'd0, busy1},    {31'd0, m_b1});
      check("rnd.busy2",    {31'd0, busy2},    {31'd0, m_b2});
      check("rnd.stall",    {31'd0, stall},    {31'd0, m_b1 | m_b2});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
